// File: rtl/input_req_ctrl_if.sv
// Router input-port bundle: upstream flit link, request/grant to the output
// arbiters, downstream flit link and status.
//   master : the input requester (drives ready, req, fout, busy, err)
//   slave  : the surrounding router / environment
interface input_req_ctrl_if #(
    parameter int FLIT_WIDTH   = 34,
    parameter int N_OF_OUTPUTS = 5
);
    logic                    fin_valid_i;
    logic [FLIT_WIDTH-1:0]   fin_data_i;
    logic                    fin_ready_o;
    logic [N_OF_OUTPUTS-1:0] req_o;
    logic [N_OF_OUTPUTS-1:0] grant_i;
    logic                    fout_valid_o;
    logic [FLIT_WIDTH-1:0]   fout_data_o;
    logic                    fout_ready_i;
    logic                    busy_o;
    logic                    err_o;

    modport master (
        input  fin_valid_i, fin_data_i, grant_i, fout_ready_i,
        output fin_ready_o, req_o, fout_valid_o, fout_data_o, busy_o, err_o
    );

    modport slave (
        output fin_valid_i, fin_data_i, grant_i, fout_ready_i,
        input  fin_ready_o, req_o, fout_valid_o, fout_data_o, busy_o, err_o
    );
endinterface

// File: rtl/input_req_ctrl.sv
// Router input-port requester.
// Buffers incoming flits in a small FIFO, decodes the destination port from
// the head flit, raises a one-hot request to that output's arbiter, streams
// the packet while granted and drops the request after the tail flit.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - input_req_ctrl_if.master: fin_* upstream link, req_o/grant_i
//          arbiter handshake, fout_* downstream link, busy_o, err_o
module input_req_ctrl #(
    parameter int FLIT_WIDTH   = 34,
    parameter int N_OF_OUTPUTS = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int DEST_LSB     = 0,
    parameter int DEST_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input_req_ctrl_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [FLIT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic [1:0]              state;
    logic [N_OF_OUTPUTS-1:0] req_q;
    logic                    err_q;

    logic [FLIT_WIDTH-1:0]   head;
    logic [1:0]              head_type;
    logic [DEST_W-1:0]       head_dest;
    logic empty, full, head_ok, granted, fout_valid, push, pop, drop, tail_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign head      = mem[rd_ptr];
    assign head_type = head[FLIT_WIDTH-1 -: 2];
    assign head_dest = head[DEST_LSB +: DEST_W];

    // HEAD (00) and HEAD_TAIL (11) are the only types with equal bits
    assign head_ok = (head_type[1] == head_type[0]) &&
                     ({1'b0, head_dest} < (DEST_W+1)'(N_OF_OUTPUTS));

    // req_q is one-hot on the latched destination, so this is grant_i[dest]
    assign granted    = |(req_q & bus.grant_i);
    assign fout_valid = (state == ST_XFER) && !empty && granted;

    assign push     = bus.fin_valid_i && !full;
    assign drop     = (state == ST_IDLE) && !empty && !head_ok;
    assign pop      = drop || (fout_valid && bus.fout_ready_i);
    // TAIL (10) and HEAD_TAIL (11) both close the packet
    assign tail_pop = fout_valid && bus.fout_ready_i && head_type[1];

    // storage has no reset: contents are only observed through count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.fin_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= drop;
            case (state)
                ST_IDLE: begin
                    if (!empty && head_ok) begin
                        req_q <= N_OF_OUTPUTS'(1) << head_dest;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (granted) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (tail_pop) begin
                        req_q <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    req_q <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fin_ready_o  = !full;
    assign bus.req_o        = req_q;
    assign bus.fout_valid_o = fout_valid;
    assign bus.fout_data_o  = head;
    assign bus.busy_o       = (state != ST_IDLE);
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_input_req_ctrl.sv
// Self-checking bench for input_req_ctrl: table of single-flit packets,
// hand-written multi-cycle sequences, and a randomized run checked against a
// packet-level reference (expected output stream + expected drop count).
module tb_input_req_ctrl;
    localparam int FW = 34;
    localparam int NO = 5;
    localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_req_ctrl_if #(.FLIT_WIDTH(FW), .N_OF_OUTPUTS(NO)) bus ();

    input_req_ctrl #(.FLIT_WIDTH(FW), .N_OF_OUTPUTS(NO), .FIFO_DEPTH(4),
                     .DEST_LSB(0), .DEST_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [FW-1:0] flit;
        logic [NO-1:0] grant;
        logic [NO-1:0] exp_req;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [FW-1:0] flit;
        logic [NO-1:0] port;
    } exp_t;

    vec_t          vecs[10];
    exp_t          exp_q[$];
    logic [FW-1:0] stream[$];
    int            exp_err;
    int            err_seen;
    bit            drv_done;
    bit            mon_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int dest);
        logic [FW-3:0] p;
        p      = $urandom();
        p[2:0] = dest[2:0];
        return {t, p};
    endfunction

    // Push a packet of n flits for dest, then stream it out; optionally
    // withdraw the grant for 3 cycles after the second flit.
    task automatic run_pkt(input int dest, input int n, input bit gap);
        logic [FW-1:0] q[$];
        logic [NO-1:0] oh;
        int k, first, last, gap_cnt;
        oh = NO'(1) << dest;
        for (int i = 0; i < n; i++)
            q.push_back(mk(i == 0 ? T_HEAD : (i == n-1 ? T_TAIL : T_BODY), dest));
        for (int i = 0; i < n; i++) begin
            bus.fin_valid_i = 1'b1;
            bus.fin_data_i  = q[i];
            tick();
        end
        bus.fin_valid_i = 1'b0;
        k = 0; first = -1; last = -1; gap_cnt = 0;
        for (int c = 0; c < 40 && k < n; c++) begin
            bus.grant_i = (gap && k == 2 && gap_cnt < 3) ? '0 : oh;
            @(negedge clk);
            if (bus.grant_i == '0) begin
                chk("gap_valid", 64'(bus.fout_valid_o), 64'(0));
                chk("gap_req", 64'(bus.req_o), 64'(oh));
                gap_cnt++;
            end else if (bus.fout_valid_o) begin
                chk("pkt_data", 64'(bus.fout_data_o), 64'(q[k]));
                if (first < 0) first = c;
                last = c;
                k++;
            end
            tick();
        end
        chk("pkt_count", 64'(k), 64'(n));
        if (!gap) chk("pkt_consecutive", 64'(last - first), 64'(n - 1));
        else      chk("gap_cycles", 64'(gap_cnt), 64'(3));
        bus.grant_i = '0;
        @(negedge clk);
        chk("pkt_end_busy", 64'(bus.busy_o), 64'(0));
        chk("pkt_end_req", 64'(bus.req_o), 64'(0));
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] bq[$];
        int idx, k, sel;
        bit acc;

        rst = 1'b1;
        bus.fin_valid_i  = 1'b1;
        bus.fin_data_i   = '0;
        bus.grant_i      = '0;
        bus.fout_ready_i = 1'b1;

        // ---- reset with fin_valid held high
        bus.fin_data_i = mk(T_HT, 1);
        tick(); tick();
        @(negedge clk);
        chk("rst_req", 64'(bus.req_o), 64'(0));
        chk("rst_fout_valid", 64'(bus.fout_valid_o), 64'(0));
        chk("rst_err", 64'(bus.err_o), 64'(0));
        tick();
        rst = 1'b0;
        bus.fin_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_fin_ready", 64'(bus.fin_ready_o), 64'(1));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        tick();

        // ---- table of single flits arriving in IDLE
        vecs[0] = '{mk(T_HT, 2),   5'b00100, 5'b00100, 1'b0};
        vecs[1] = '{mk(T_HT, 0),   5'b00001, 5'b00001, 1'b0};
        vecs[2] = '{mk(T_HT, 4),   5'b10000, 5'b10000, 1'b0};
        vecs[3] = '{mk(T_HT, 3),   5'b00100, 5'b01000, 1'b0};
        vecs[4] = '{mk(T_HT, 1),   5'b11101, 5'b00010, 1'b0};
        vecs[5] = '{mk(T_BODY, 1), 5'b00000, 5'b00000, 1'b1};
        vecs[6] = '{mk(T_TAIL, 2), 5'b00000, 5'b00000, 1'b1};
        vecs[7] = '{mk(T_HT, 5),   5'b00000, 5'b00000, 1'b1};
        vecs[8] = '{mk(T_HEAD, 6), 5'b00000, 5'b00000, 1'b1};
        vecs[9] = '{mk(T_HT, 7),   5'b00000, 5'b00000, 1'b1};
        for (int v = 0; v < 10; v++) begin
            bus.fin_valid_i = 1'b1;
            bus.fin_data_i  = vecs[v].flit;
            tick();
            bus.fin_valid_i = 1'b0;
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_req", v), 64'(bus.req_o), 64'(vecs[v].exp_req));
            chk($sformatf("vec%0d_err", v), 64'(bus.err_o), 64'(vecs[v].exp_err));
            tick();
            if (vecs[v].exp_err) begin
                @(negedge clk);
                chk($sformatf("vec%0d_err_pulse", v), 64'(bus.err_o), 64'(0));
                chk($sformatf("vec%0d_req_idle", v), 64'(bus.req_o), 64'(0));
                tick();
                continue;
            end
            bus.grant_i = vecs[v].grant;
            if ((vecs[v].grant & vecs[v].exp_req) == '0) begin
                tick(); tick();
                @(negedge clk);
                chk($sformatf("vec%0d_wrong_grant_valid", v), 64'(bus.fout_valid_o), 64'(0));
                chk($sformatf("vec%0d_wrong_grant_req", v), 64'(bus.req_o), 64'(vecs[v].exp_req));
                tick();
                bus.grant_i = vecs[v].exp_req;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_req_state_valid", v), 64'(bus.fout_valid_o), 64'(0));
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", v), 64'(bus.fout_valid_o), 64'(1));
            chk($sformatf("vec%0d_out_data", v), 64'(bus.fout_data_o), 64'(vecs[v].flit));
            tick();
            bus.grant_i = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_req_drop", v), 64'(bus.req_o), 64'(0));
            chk($sformatf("vec%0d_busy", v), 64'(bus.busy_o), 64'(0));
            tick();
        end

        // ---- 4-flit packet, grant held; then same with a 3-cycle grant gap
        run_pkt(1, 4, 1'b0);
        run_pkt(1, 4, 1'b1);

        // ---- backpressure: 6-flit packet into a 4-deep buffer
        bus.fout_ready_i = 1'b0;
        bq.delete();
        for (int i = 0; i < 6; i++)
            bq.push_back(mk(i == 0 ? T_HEAD : (i == 5 ? T_TAIL : T_BODY), 3));
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.fin_valid_i = 1'b1;
            bus.fin_data_i  = bq[idx];
            @(negedge clk);
            acc = bus.fin_ready_o;
            tick();
            if (acc) idx++;
        end
        @(negedge clk);
        chk("bp_accepted", 64'(idx), 64'(4));
        chk("bp_fin_ready", 64'(bus.fin_ready_o), 64'(0));
        tick();
        bus.grant_i      = 5'b01000;
        bus.fout_ready_i = 1'b1;
        k = 0;
        fork
            begin
                for (int c = 0; c < 30 && idx < 6; c++) begin
                    bus.fin_valid_i = 1'b1;
                    bus.fin_data_i  = bq[idx];
                    @(negedge clk);
                    acc = bus.fin_ready_o;
                    tick();
                    if (acc) idx++;
                end
                bus.fin_valid_i = 1'b0;
            end
            begin
                for (int c = 0; c < 30 && k < 6; c++) begin
                    @(negedge clk);
                    if (bus.fout_valid_o && bus.fout_ready_i) begin
                        chk("bp_data", 64'(bus.fout_data_o), 64'(bq[k]));
                        k++;
                    end
                    tick();
                end
            end
        join
        chk("bp_in_count", 64'(idx), 64'(6));
        chk("bp_out_count", 64'(k), 64'(6));
        bus.grant_i = '0;
        @(negedge clk);
        chk("bp_busy", 64'(bus.busy_o), 64'(0));
        tick();

        // ---- reset in the middle of a packet
        bus.fin_valid_i = 1'b1;
        bus.fin_data_i  = mk(T_HEAD, 2);
        tick();
        bus.fin_data_i  = mk(T_BODY, 2);
        tick();
        bus.fin_valid_i = 1'b0;
        bus.grant_i     = 5'b00100;
        tick();
        @(negedge clk);
        chk("mid_busy", 64'(bus.busy_o), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.grant_i = '0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(bus.busy_o), 64'(0));
        chk("mid_rst_req", 64'(bus.req_o), 64'(0));
        chk("mid_rst_valid", 64'(bus.fout_valid_o), 64'(0));
        tick(); tick();
        @(negedge clk);
        chk("mid_rst_flushed_busy", 64'(bus.busy_o), 64'(0));
        chk("mid_rst_flushed_err", 64'(bus.err_o), 64'(0));
        tick();

        // ---- randomized packets with stray/bad flits
        exp_q.delete();
        stream.delete();
        exp_err = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) < 6) begin
                int len, dest;
                len  = $urandom_range(1, 5);
                dest = $urandom_range(0, 4);
                for (int i = 0; i < len; i++) begin
                    logic [FW-1:0] f;
                    f = mk(len == 1 ? T_HT : (i == 0 ? T_HEAD : (i == len-1 ? T_TAIL : T_BODY)), dest);
                    stream.push_back(f);
                    exp_q.push_back('{f, NO'(1) << dest});
                end
            end else begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       stream.push_back(mk(T_BODY, $urandom_range(0, 7)));
                    1:       stream.push_back(mk(T_TAIL, $urandom_range(0, 7)));
                    2:       stream.push_back(mk(T_HEAD, $urandom_range(5, 7)));
                    default: stream.push_back(mk(T_HT, $urandom_range(5, 7)));
                endcase
                exp_err++;
            end
        end
        err_seen = 0;
        drv_done = 1'b0;
        mon_done = 1'b0;
        fork
            begin
                int i;
                bit a;
                i = 0;
                for (int c = 0; c < 6000 && i < stream.size(); c++) begin
                    bus.fin_valid_i = ($urandom_range(0, 3) != 0);
                    bus.fin_data_i  = stream[i];
                    @(negedge clk);
                    a = bus.fin_valid_i && bus.fin_ready_o;
                    tick();
                    if (a) i++;
                end
                bus.fin_valid_i = 1'b0;
                drv_done = 1'b1;
            end
            begin
                for (int c = 0; c < 7000 && !mon_done; c++) begin
                    tick();
                    bus.grant_i = (($urandom_range(0, 3) != 0) ? bus.req_o : '0) |
                                  (NO'($urandom()) & ~bus.req_o & {NO{$urandom_range(0, 1) == 1}});
                    bus.fout_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                int quiet;
                exp_t e;
                quiet = 0;
                for (int c = 0; c < 7000 && quiet < 4; c++) begin
                    @(negedge clk);
                    if (bus.err_o) err_seen++;
                    chk("rand_req_onehot", 64'($countones(bus.req_o) <= 1), 64'(1));
                    chk("rand_valid_outside_xfer", 64'(bus.fout_valid_o && !bus.busy_o), 64'(0));
                    if (bus.fout_valid_o && bus.fout_ready_i) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_extra_flit", 64'(bus.fout_data_o), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("rand_data", 64'(bus.fout_data_o), 64'(e.flit));
                            chk("rand_port", 64'(bus.req_o), 64'(e.port));
                        end
                    end
                    if (drv_done && exp_q.size() == 0) quiet++;
                end
                mon_done = 1'b1;
            end
        join
        chk("rand_err_count", 64'(err_seen), 64'(exp_err));
        chk("rand_flits_left", 64'(exp_q.size()), 64'(0));
        bus.grant_i = '0;
        @(negedge clk);
        chk("rand_end_busy", 64'(bus.busy_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
